// File: rtl/micro_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// micro_seq_pkg
// Purpose : Shared definitions for the micro-sequencer: the default micro-PC
//           width, the next_sel code points carried in each microinstruction,
//           and the sequencer state encoding.
// Ports   : none (package)
// Config  : MICRO_SUBROUTINE_EN is interpreted by micro_sequencer, not here.
// -----------------------------------------------------------------------------
package micro_seq_pkg;

   localparam int UPC_W_DEF = 6;

   localparam logic [2:0] NS_INC      = 3'b000;
   localparam logic [2:0] NS_DISPATCH = 3'b001;
   localparam logic [2:0] NS_BRANCH   = 3'b010;
   localparam logic [2:0] NS_JUMP     = 3'b011;
   localparam logic [2:0] NS_FETCH    = 3'b100;
   localparam logic [2:0] NS_CALL     = 3'b101;
   localparam logic [2:0] NS_RET      = 3'b110;
   localparam logic [2:0] NS_HALT     = 3'b111;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_WAIT_OP = 2'd1,
      ST_HALT    = 2'd2
   } seq_state_t;

endpackage

// File: rtl/micro_sequencer_if.sv
// -----------------------------------------------------------------------------
// micro_sequencer_if
// Purpose : Bundles the sequencer's control-side inputs and micro-PC/status
//           outputs. clk and rst_n are not part of the bundle.
// Signals : rom_offset, opcode_valid, next_sel, branch_addr, cond, stall
//           (driven by master), upc, dispatch_ack, halted, stack_err
//           (driven by slave = the sequencer).
// -----------------------------------------------------------------------------
interface micro_sequencer_if
   import micro_seq_pkg::*;
#(
   parameter int UPC_W = UPC_W_DEF
);
   logic [UPC_W-1:0] rom_offset;
   logic             opcode_valid;
   logic [2:0]       next_sel;
   logic [UPC_W-1:0] branch_addr;
   logic             cond;
   logic             stall;
   logic [UPC_W-1:0] upc;
   logic             dispatch_ack;
   logic             halted;
   logic             stack_err;

   modport master (
      output rom_offset, opcode_valid, next_sel, branch_addr, cond, stall,
      input  upc, dispatch_ack, halted, stack_err
   );

   modport slave (
      input  rom_offset, opcode_valid, next_sel, branch_addr, cond, stall,
      output upc, dispatch_ack, halted, stack_err
   );
endinterface

// File: rtl/micro_stack.sv
// -----------------------------------------------------------------------------
// micro_stack
// Purpose : LIFO return-address stack, DEPTH entries of UPC_W bits. Only the
//           pointer is reset; entry contents are left as-is.
// Ports   : clk, rst_n (sync, active-low), push/push_data, pop/pop_data
//           (pop_data shows the current top entry combinationally),
//           full, empty.
// -----------------------------------------------------------------------------
module micro_stack #(
   parameter int UPC_W = 6,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [UPC_W-1:0] push_data,
   input  logic             pop,
   output logic [UPC_W-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int SP_W  = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [UPC_W-1:0] mem [DEPTH];
   logic [SP_W-1:0]  sp;
   logic [IDX_W-1:0] top_idx;

   assign full     = (sp == SP_W'(DEPTH));
   assign empty    = (sp == '0);
   assign top_idx  = IDX_W'(sp - 1'b1);
   assign pop_data = empty ? '0 : mem[top_idx];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sp <= '0;
      end else if (push && !full) begin
         sp <= sp + 1'b1;
      end else if (pop && !empty) begin
         sp <= sp - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[IDX_W'(sp)] <= push_data;
      end
   end
endmodule

// File: rtl/micro_sequencer.sv
// -----------------------------------------------------------------------------
// micro_sequencer
// Purpose : Micro-PC sequencer for a microcoded control unit. Each cycle the
//           current microinstruction's next_sel picks the next micro-PC
//           (INC, DISPATCH, BRANCH, JUMP, FETCH, CALL, RET, HALT). All outputs
//           are registered; upc changes one clock after the decoding cycle.
// Ports   : clk, rst_n (sync, active-low), bus (micro_sequencer_if.slave).
// Config  : `define MICRO_SUBROUTINE_EN adds a STACK_DEPTH-entry return stack
//           for CALL/RET. Without it CALL acts as JUMP, RET acts as FETCH and
//           stack_err is tied low.
// -----------------------------------------------------------------------------
module micro_sequencer
   import micro_seq_pkg::*;
#(
   parameter int UPC_W       = UPC_W_DEF,
   parameter int STACK_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   micro_sequencer_if.slave     bus
);
   seq_state_t       state;
   logic [UPC_W-1:0] upc_q;
   logic [UPC_W-1:0] upc_inc;
   logic             ack_q;
   logic             halted_q;

   if (STACK_DEPTH < 1) begin : g_bad_depth
      $error("micro_sequencer: STACK_DEPTH must be at least 1");
   end

   assign upc_inc = upc_q + UPC_W'(1);

`ifdef MICRO_SUBROUTINE_EN
   logic             err_q;
   logic             decode;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic [UPC_W-1:0] pop_data;

   // Stack operations only happen on a live RUN-state decode.
   assign decode = (state == ST_RUN) && !bus.stall;
   assign push   = decode && (bus.next_sel == NS_CALL);
   assign pop    = decode && (bus.next_sel == NS_RET);

   micro_stack #(
      .UPC_W (UPC_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (upc_inc),
      .pop       (pop),
      .pop_data  (pop_data),
      .full      (full),
      .empty     (empty)
   );

   assign bus.stack_err = err_q;
`else
   assign bus.stack_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         upc_q    <= '0;
         ack_q    <= 1'b0;
         halted_q <= 1'b0;
`ifdef MICRO_SUBROUTINE_EN
         err_q    <= 1'b0;
`endif
      end else begin
         ack_q <= 1'b0;
         case (state)
            ST_HALT: begin
               // Sticky until reset.
            end
            ST_WAIT_OP: begin
               // next_sel is ignored while waiting for a usable opcode.
               if (!bus.stall && bus.opcode_valid) begin
                  upc_q <= bus.rom_offset;
                  ack_q <= 1'b1;
                  state <= ST_RUN;
               end
            end
            default: begin
               if (!bus.stall) begin
                  case (bus.next_sel)
                     NS_INC:      upc_q <= upc_inc;
                     NS_DISPATCH: begin
                        if (bus.opcode_valid) begin
                           upc_q <= bus.rom_offset;
                           ack_q <= 1'b1;
                        end else begin
                           state <= ST_WAIT_OP;
                        end
                     end
                     NS_BRANCH:   upc_q <= bus.cond ? bus.branch_addr : upc_inc;
                     NS_JUMP:     upc_q <= bus.branch_addr;
                     NS_FETCH:    upc_q <= '0;
`ifdef MICRO_SUBROUTINE_EN
                     NS_CALL: begin
                        // Overflow still takes the jump; the return is lost.
                        upc_q <= bus.branch_addr;
                        if (full) err_q <= 1'b1;
                     end
                     NS_RET: begin
                        if (empty) begin
                           upc_q <= '0;
                           err_q <= 1'b1;
                        end else begin
                           upc_q <= pop_data;
                        end
                     end
`else
                     NS_CALL:     upc_q <= bus.branch_addr;
                     NS_RET:      upc_q <= '0;
`endif
                     NS_HALT: begin
                        state    <= ST_HALT;
                        halted_q <= 1'b1;
                     end
                     default:     upc_q <= upc_q;
                  endcase
               end
            end
         endcase
      end
   end

   assign bus.upc          = upc_q;
   assign bus.dispatch_ack = ack_q;
   assign bus.halted       = halted_q;
endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter UPC_W, default 6, micro-PC width; matches decoder_complex rom_offset width.
REQ-002 Parameter STACK_DEPTH, default 4, return-stack entries; used only when MICRO_SUBROUTINE_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 rom_offset  input  UPC_W  dispatch target from decoder_complex for the current opcode.
REQ-006 opcode_valid  input  1  high when the opcode driving decoder_complex is stable and rom_offset is usable.
REQ-007 next_sel  input  3  next-address code from the current microinstruction.
REQ-008 branch_addr  input  UPC_W  jump/branch/call target field from the current microinstruction.
REQ-009 cond  input  1  branch condition selected by datapath (e.g. accumulator zero).
REQ-010 stall  input  1  freeze sequencer for this cycle.
REQ-011 upc  output  UPC_W  registered micro-PC addressing the control ROM.
REQ-012 dispatch_ack  output  1  one-cycle pulse when a dispatch is taken; opcode may change afterwards.
REQ-013 halted  output  1  high while in HALT.
REQ-014 stack_err  output  1  sticky return-stack overflow/underflow flag.

Function
REQ-015 next_sel codes: 000 INC, 001 DISPATCH, 010 BRANCH (if cond), 011 JUMP, 100 FETCH, 101 CALL, 110 RET, 111 HALT.
REQ-016 States: RUN, WAIT_OP, HALT; reset enters RUN.
REQ-017 Priority each cycle: reset > HALT state > stall > next_sel decode.
REQ-018 stall high: upc, state, stack, and stack_err hold; dispatch_ack low.
REQ-019 INC: upc <= upc+1 modulo 2^UPC_W (63 wraps to 0).
REQ-020 DISPATCH with opcode_valid high: upc <= rom_offset, dispatch_ack high the same cycle the update is registered, state stays RUN.
REQ-021 DISPATCH with opcode_valid low: upc holds, state -> WAIT_OP; in WAIT_OP upc holds and next_sel is ignored until opcode_valid, then upc <= rom_offset, dispatch_ack pulses, state -> RUN.
REQ-022 BRANCH: upc <= branch_addr if cond, else upc+1; JUMP: upc <= branch_addr unconditionally.
REQ-023 FETCH: upc <= 0 (fetch microroutine entry).
REQ-024 HALT: upc holds, state -> HALT, halted high from the next cycle; only reset leaves HALT.
REQ-025 Latency: every upc update is visible exactly one clk after the decoding cycle; no combinational path from inputs to upc.
REQ-026 dispatch_ack never high for two consecutive cycles from a single DISPATCH.

Reset
REQ-027 rst_n low at a rising edge: upc=0, state=RUN, dispatch_ack=0, halted=0, stack_err=0, stack pointer=0; applies mid-WAIT_OP, mid-HALT, and with a full stack.
REQ-028 Stack entry contents are not reset; only the pointer.

Configuration
REQ-029 Macro MICRO_SUBROUTINE_EN defined: CALL pushes upc+1 and jumps to branch_addr; RET pops into upc.
REQ-030 CALL with stack full: no push, jump still taken, stack_err set; RET with stack empty: upc <= 0, stack_err set.
REQ-031 Macro undefined: CALL behaves as JUMP, RET behaves as FETCH, no stack storage instantiated, stack_err tied 0.

Structure
REQ-032 Package micro_seq_pkg holds next_sel code constants, state encoding, and default UPC_W.
REQ-033 Sub-module micro_stack (LIFO, push/pop/full/empty, STACK_DEPTH x UPC_W) instantiated only under MICRO_SUBROUTINE_EN.

Verification
REQ-034 Reset, then next_sel=INC for 70 cycles -> upc counts 0..63, wraps to 0 at cycle 64, reaches 5 at cycle 69.
REQ-035 upc=0x05, DISPATCH, opcode_valid=0 for 3 cycles, then 1 with rom_offset=0x2A -> upc holds 0x05 for 3 cycles, then 0x2A with one dispatch_ack pulse.
REQ-036 BRANCH branch_addr=0x10 with cond=1 from upc=0x03 -> 0x10; repeat with cond=0 -> 0x04; DISPATCH with stall=1 -> upc holds, no ack.
REQ-037 MICRO_SUBROUTINE_EN: from upc=0x08 CALL 0x20, RET -> upc 0x20 then 0x09; 5 nested CALLs -> stack_err=1 after the 5th, target still taken; reset clears stack_err.
REQ-038 HALT at upc=0x11 -> halted=1, upc stays 0x11 under any next_sel; rst_n low one cycle -> upc=0, halted=0.
